// File: rtl/writeback_if.sv
// Bundle between the MEM/decode side and the writeback stage: MEM results in,
// read ports, writeback slot, redirect and retire count out.
interface writeback_if;
  logic [31:0] Result;
  logic [6:0]  RdWb;
  logic        Wrenable;
  logic [6:0]  BranchResultOut;
  logic        stall;
  logic [6:0]  RsA;
  logic [6:0]  RsB;
  logic [31:0] DataA;
  logic [31:0] DataB;
  logic        WbEn;
  logic [6:0]  WbRd;
  logic [31:0] WbData;
  logic        BranchTaken;
  logic [6:0]  BranchTarget;
  logic        Flush;
  logic [31:0] RetireCount;

  modport master (
    output Result, RdWb, Wrenable, BranchResultOut, stall, RsA, RsB,
    input  DataA, DataB, WbEn, WbRd, WbData, BranchTaken, BranchTarget, Flush, RetireCount
  );

  modport slave (
    input  Result, RdWb, Wrenable, BranchResultOut, stall, RsA, RsB,
    output DataA, DataB, WbEn, WbRd, WbData, BranchTaken, BranchTarget, Flush, RetireCount
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB slot register, 128x32 register file with write-through
// bypass on the read ports, branch redirect/flush and a retire counter.
module writeback_stage (
  input  logic       clk,
  input  logic       rst,
  writeback_if.slave wb
);

  logic        wb_en_q, wb_en_d;
  logic [6:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        br_taken_q, br_taken_d;
  logic [6:0]  br_target_q, br_target_d;
  logic [31:0] retire_count_q, retire_count_d;
  logic [31:0] rf_q [128];
  logic [31:0] rf_d [128];
  logic        load_bubble;

  // A taken branch in the slot squashes whatever MEM offers this cycle.
  assign load_bubble = wb.stall | br_taken_q;

  always_comb begin
    rf_d = rf_q;
    if (wb_en_q) begin
      rf_d[wb_rd_q] = wb_data_q;
    end

    retire_count_d = retire_count_q;
    if (wb_en_q || br_taken_q) begin
      retire_count_d = retire_count_q + 32'd1;
    end

    wb_en_d     = 1'b0;
    wb_rd_d     = '0;
    wb_data_d   = '0;
    br_taken_d  = 1'b0;
    br_target_d = '0;
    if (!load_bubble) begin
      wb_en_d     = wb.Wrenable && (wb.RdWb != 7'd0);
      wb_rd_d     = wb.RdWb;
      wb_data_d   = wb.Result;
      br_taken_d  = (wb.BranchResultOut != 7'd0);
      br_target_d = wb.BranchResultOut;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_q        <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      br_taken_q     <= 1'b0;
      br_target_q    <= '0;
      retire_count_q <= '0;
      for (int i = 0; i < 128; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      wb_en_q        <= wb_en_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      br_taken_q     <= br_taken_d;
      br_target_q    <= br_target_d;
      retire_count_q <= retire_count_d;
      rf_q           <= rf_d;
    end
  end

  always_comb begin
    wb.DataA = rf_q[wb.RsA];
    if (wb.RsA == 7'd0) begin
      wb.DataA = '0;
    end else if (wb_en_q && (wb_rd_q == wb.RsA)) begin
      wb.DataA = wb_data_q;
    end
    wb.DataB = rf_q[wb.RsB];
    if (wb.RsB == 7'd0) begin
      wb.DataB = '0;
    end else if (wb_en_q && (wb_rd_q == wb.RsB)) begin
      wb.DataB = wb_data_q;
    end
  end

  assign wb.WbEn         = wb_en_q;
  assign wb.WbRd         = wb_rd_q;
  assign wb.WbData       = wb_data_q;
  assign wb.BranchTaken  = br_taken_q;
  assign wb.BranchTarget = br_target_q;
  assign wb.Flush        = br_taken_q;
  assign wb.RetireCount  = retire_count_q;

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; the ports are listed below, clock and reset first.
REQ-002 SHALL expose: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL expose: rst  in  1  synchronous, active-high reset.
REQ-004 SHALL expose: Result  in  32  write data from the MEM stage.
REQ-005 SHALL expose: RdWb  in  7  destination register from the MEM stage.
REQ-006 SHALL expose: Wrenable  in  1  write request from the MEM stage.
REQ-007 SHALL expose: BranchResultOut  in  7  branch target from the MEM stage; nonzero means taken.
REQ-008 SHALL expose: stall  in  1  hold request; the MEM outputs are not new this cycle.
REQ-009 SHALL expose: RsA, RsB  in  7 each  decode-stage read addresses.
REQ-010 SHALL expose: DataA, DataB  out  32 each  read data, combinational.
REQ-011 SHALL expose: WbEn, WbRd, WbData  out  1/7/32  registered writeback slot, also used for forwarding.
REQ-012 SHALL expose: BranchTaken, BranchTarget, Flush  out  1/7/1  PC redirect and flush of upstream stages.
REQ-013 SHALL expose: RetireCount  out  32  count of retired writes and taken branches.

Function
REQ-014 SHALL contain a 128x32 register file in which register 0 always reads 0 and writes to register 0 are discarded.
REQ-015 SHALL capture {Result, RdWb, Wrenable, BranchResultOut} into the MEM/WB register on each rising edge, unless REQ-016 or REQ-017 applies.
REQ-016 SHALL load a bubble (WbEn=0, WbRd=0, WbData=0, BranchTaken=0, BranchTarget=0) when stall=1; a held instruction is therefore never written or counted twice.
REQ-017 SHALL load a bubble when Flush=1 in the same cycle; this squashes the instruction that follows a taken branch.
REQ-018 SHALL drive WbEn = captured Wrenable AND (captured RdWb != 0).
REQ-019 SHALL write WbData into register WbRd at the rising edge that ends the cycle in which WbEn=1; write latency is 2 edges from MEM output to architectural state.
REQ-020 SHALL drive BranchTaken=1 and BranchTarget = captured BranchResultOut for exactly one cycle when the captured BranchResultOut != 0; otherwise BranchTaken=0 and BranchTarget=0.
REQ-021 SHALL drive Flush = BranchTaken, combinationally.
REQ-022 SHALL allow a single slot to carry both a write and a taken branch (CP opcode); the write and the redirect then both take effect.
REQ-023 SHALL drive DataA as follows: 0 if RsA=0; else WbData if WbEn=1 and WbRd=RsA (write-through bypass); else the register file contents. DataB follows the same rule using RsB.
REQ-024 SHALL increment RetireCount by 1 at each edge that ends a cycle with WbEn=1 or BranchTaken=1 (increment by 1, not 2, if both); it wraps from 0xFFFFFFFF to 0.
REQ-025 SHALL give rst priority over stall and Flush.

Reset
REQ-026 SHALL, when rst=1 at an edge, clear WbEn, WbRd, WbData, BranchTaken, BranchTarget and RetireCount to 0, and therefore Flush to 0.
REQ-027 SHALL clear all 128 registers to 0 on reset; a write pending in the slot when rst is asserted is lost.

Verification
REQ-028 SHALL be checked with: Result=0x12345678, RdWb=5, Wrenable=1 for 1 cycle -> WbEn=1 next cycle; RsA=5 gives DataA=0x12345678 via bypass, then via the register file from the following cycle; RetireCount=1.
REQ-029 SHALL be checked with: RdWb=0, Wrenable=1, Result=0xFFFFFFFF -> WbEn=0; RsA=0 gives DataA=0; RetireCount unchanged.
REQ-030 SHALL be checked with: BranchResultOut=0x2A, then a write to r7 in the next cycle -> BranchTaken=1, BranchTarget=0x2A, Flush=1 for 1 cycle; the r7 write is squashed; r7 stays 0.
REQ-031 SHALL be checked with: Wrenable=1, RdWb=3, Result=9 held for 3 cycles with stall=1 on cycles 2-3 -> r3=9 written once; RetireCount=1.
REQ-032 SHALL be checked with: CP slot RdWb=10, Result=0xAB, BranchResultOut=4 -> r10=0xAB, BranchTaken=1, RetireCount +1.
REQ-033 SHALL be checked with: rst=1 asserted while WbEn=1 for r20 -> r20=0, all outputs 0; RetireCount preset to 0xFFFFFFFF (after a fresh run) wraps to 0 on the next retire.
